// File: rtl/double_ask_tx.sv
// 2ASK (on-off keying) transmitter: serializes a 16-bit frame MSB first and gates a sine LUT.
// Optional macro DAC_OFFSET_BINARY_EN selects offset-binary output for a unipolar DAC.
module double_ask_tx #(
  parameter int CLK_PER_BIT = 50,
  parameter int FRAME_BITS  = 16,
  parameter int CAR_PERIOD  = 10
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [FRAME_BITS-1:0] data_in,
  output logic [15:0]           tx
);

  localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int PW = (CAR_PERIOD > 1) ? $clog2(CAR_PERIOD) : 1;

`ifdef DAC_OFFSET_BINARY_EN
  localparam logic [15:0] IDLE_LEVEL = 16'h8000;
`else
  localparam logic [15:0] IDLE_LEVEL = 16'h0000;
`endif

  logic [CW-1:0]         clk_cnt;
  logic [BW-1:0]         bit_idx;
  logic [PW-1:0]         car_ph;
  logic [FRAME_BITS-1:0] data_reg;
  logic [FRAME_BITS-1:0] data_msb_first;
  logic                  frame_start;
  logic                  cur_bit;
  logic                  cnt_wrap;
  logic [15:0]           lut_val;
  logic [15:0]           tx_next;

  // Bit-reverse the latched word so bit_idx indexes it directly in MSB-first order.
  generate
    for (genvar gi = 0; gi < FRAME_BITS; gi++) begin : g_rev
      assign data_msb_first[gi] = data_reg[FRAME_BITS-1-gi];
    end
  endgenerate

  assign cnt_wrap    = (clk_cnt == CW'(CLK_PER_BIT - 1));
  assign frame_start = (clk_cnt == '0) && (bit_idx == '0);
  assign cur_bit     = frame_start ? data_in[FRAME_BITS-1] : data_msb_first[bit_idx];

  always_comb begin
    lut_val = 16'h0000;
    case (car_ph)
      PW'(0): lut_val = 16'sd0;
      PW'(1): lut_val = 16'sd19260;
      PW'(2): lut_val = 16'sd31163;
      PW'(3): lut_val = 16'sd31163;
      PW'(4): lut_val = 16'sd19260;
      PW'(5): lut_val = 16'sd0;
      PW'(6): lut_val = -16'sd19260;
      PW'(7): lut_val = -16'sd31163;
      PW'(8): lut_val = -16'sd31163;
      PW'(9): lut_val = -16'sd19260;
      default: lut_val = 16'h0000;
    endcase
  end

  always_comb begin
    tx_next = IDLE_LEVEL;
    if (cur_bit) begin
`ifdef DAC_OFFSET_BINARY_EN
      tx_next = lut_val ^ 16'h8000;
`else
      tx_next = lut_val;
`endif
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      clk_cnt  <= '0;
      bit_idx  <= '0;
      car_ph   <= '0;
      data_reg <= '0;
      tx       <= IDLE_LEVEL;
    end else begin
      tx <= tx_next;
      if (frame_start) begin
        data_reg <= data_in;
      end
      if (cnt_wrap) begin
        clk_cnt <= '0;
        bit_idx <= (bit_idx == BW'(FRAME_BITS - 1)) ? '0 : bit_idx + 1'b1;
      end else begin
        clk_cnt <= clk_cnt + 1'b1;
      end
      // Carrier phase free-runs across bit and frame boundaries.
      car_ph <= (car_ph == PW'(CAR_PERIOD - 1)) ? '0 : car_ph + 1'b1;
    end
  end

endmodule

// File: tb/tb_double_ask_tx.sv
// Directed bench for double_ask_tx: a frame-position model pushes the expected sample per edge
// to a scoreboard queue, which is popped and compared one clock later.
module tb_double_ask_tx;

  logic        sys_clk;
  logic        sys_rst;
  logic [15:0] data_in;
  logic [15:0] tx;

  double_ask_tx dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .data_in (data_in),
    .tx      (tx)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  int          sine[10] = '{0, 19260, 31163, 31163, 19260, 0, -19260, -31163, -31163, -19260};

  // Reference model state: position within the frame, carrier phase, latched word.
  int          frame_pos = 0;
  int          phase     = 0;
  logic [15:0] word      = 16'h0000;

`ifdef DAC_OFFSET_BINARY_EN
  localparam logic [15:0] IDLE = 16'h8000;
`else
  localparam logic [15:0] IDLE = 16'h0000;
`endif

  function automatic logic [15:0] carrier(input int ph);
    logic [15:0] v;
    v = 16'(sine[ph]);
`ifdef DAC_OFFSET_BINARY_EN
    v = 16'(sine[ph] + 32768);
`endif
    return v;
  endfunction

  task automatic step(input logic rst, input logic [15:0] din, input string tag);
    logic        b;
    logic [15:0] e;
    logic [15:0] got;
    @(negedge sys_clk);
    sys_rst = rst;
    data_in = din;
    if (rst) begin
      e         = IDLE;
      frame_pos = 0;
      phase     = 0;
      word      = 16'h0000;
    end else begin
      if (frame_pos == 0) word = din;
      b         = word[15 - frame_pos / 50];
      e         = b ? carrier(phase) : IDLE;
      phase     = (phase + 1) % 10;
      frame_pos = (frame_pos + 1) % 800;
    end
    exp_q.push_back(e);
    @(posedge sys_clk);
    #1;
    got = tx;
    e   = exp_q.pop_front();
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s tx=%0d (0x%h) expected=%0d (0x%h)", tag, $signed(got), got, $signed(e), e);
    end
  endtask

  task automatic run(input int n, input logic rst, input logic [15:0] din, input string tag);
    int e0;
    e0 = errors;
    for (int i = 0; i < n; i++) step(rst, din, tag);
    $display("step %-14s cycles=%0d rst=%0b data_in=0x%h errors_in_step=%0d",
             tag, n, rst, din, errors - e0);
  endtask

  initial begin
    sys_rst = 1'b1;
    data_in = 16'hFFFF;
    // Reset held with all-ones data: output must stay idle.
    run(5, 1'b1, 16'hFFFF, "reset_hold");
    // Release with FEC8: first full frame, zero windows at bits 7, 10-11, 13-15.
    run(800, 1'b0, 16'hFEC8, "frame_fec8");
    // New word at frame boundary: seven leading zeros then carrier from phase 0.
    run(1100, 1'b0, 16'h0137, "frame_0137");
    // Mid-frame change must not disturb the running frame.
    run(500, 1'b0, 16'hF0F0, "midframe_f0f0");
    run(800, 1'b0, 16'hF0F0, "frame_f0f0");
    // Reset mid-bit, then restart aligned to release.
    run(123, 1'b0, 16'hA5C3, "pre_reset");
    run(3, 1'b1, 16'hA5C3, "mid_reset");
    run(420, 1'b0, 16'hA5C3, "after_reset");
    run(10, 1'b0, 16'h0000, "zero_word");
    run(800, 1'b0, 16'hFFFF, "ones_frame");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
